// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_unit
// Purpose  : Sequences the shift-add multiplier and owns the HI/LO registers.
// Revision : 1.0
// ============================================================================
module hilo_unit #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 mul_start,
    output logic [5:0]           mul_signal,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;
    localparam logic [5:0] c_SIG_RUN  = 6'b011001;

    localparam int          c_CW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic                r_mul_start;
    logic [5:0]          r_mul_signal;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_result;
    logic                r_result_valid;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    // busy is kept as its own flop so it is a clean registered output
    // that tracks state != IDLE exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_mul_start    <= 1'b0;
            r_mul_signal   <= 6'b000000;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_hi           <= '0;
            r_lo           <= '0;
        end else begin
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (funct)
                            c_FN_MULTU: begin
                                r_state      <= S_RUN;
                                r_cnt        <= '0;
                                r_mul_start  <= 1'b1;
                                r_mul_signal <= c_SIG_RUN;
                                r_busy       <= 1'b1;
                            end
                            c_FN_MFHI: begin
                                r_result       <= r_hi;
                                r_result_valid <= 1'b1;
                            end
                            c_FN_MFLO: begin
                                r_result       <= r_lo;
                                r_result_valid <= 1'b1;
                            end
                            c_FN_MTHI: r_hi <= data_in;
                            c_FN_MTLO: r_lo <= data_in;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    // The load strobe covers only the first round cycle.
                    r_mul_start <= 1'b0;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_mul_signal <= 6'b000000;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_hi    <= mul_product[2*WIDTH-1:WIDTH];
                    r_lo    <= mul_product[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_mul_start  <= 1'b0;
                    r_mul_signal <= 6'b000000;
                end
            endcase
        end
    end

    assign mul_start    = r_mul_start;
    assign mul_signal   = r_mul_signal;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign hi           = r_hi;
    assign lo           = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_unit
// Purpose  : Directed self-checking bench for hilo_unit.
// Revision : 1.0
// ============================================================================
module tb_hilo_unit;

    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_MFHI  = 6'b010000;
    localparam logic [5:0] c_MFLO  = 6'b010010;
    localparam logic [5:0] c_MTHI  = 6'b010001;
    localparam logic [5:0] c_MTLO  = 6'b010011;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] data_in;
    logic [63:0] mul_product;
    logic        mul_start;
    logic [5:0]  mul_signal;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    hilo_unit #(.WIDTH(32), .ROUNDS(32)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .funct       (funct),
        .data_in     (data_in),
        .mul_product (mul_product),
        .mul_start   (mul_start),
        .mul_signal  (mul_signal),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_valid(result_valid),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && done) done_cnt++;
        if (done && result_valid) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] d);
        op_valid = 1'b1;
        funct    = f;
        data_in  = d;
        tick();
        op_valid = 1'b0;
    endtask

    // Runs one MULTU; optionally holds an MFLO request from cycle 5 onwards.
    task automatic run_mul(input string tag, input logic [63:0] prod, input bit hold_mflo);
        int lat, busy_c, start_c, sig_c, rv_c;
        mul_product = prod;
        issue(c_MULTU, 32'h0);
        lat = 0; busy_c = 0; start_c = 0; sig_c = 0; rv_c = 0;
        while (!done && lat < 100) begin
            if (busy) busy_c++;
            if (mul_start) start_c++;
            if (mul_signal == 6'b011001) sig_c++;
            if (result_valid) rv_c++;
            if (hold_mflo && lat == 5) begin
                op_valid = 1'b1;
                funct    = c_MFLO;
            end
            tick();
            lat++;
        end
        check_eq({tag, "_done_latency"}, 64'(lat), 64'd33);
        check_eq({tag, "_busy_cycles"}, 64'(busy_c), 64'd33);
        check_eq({tag, "_start_cycles"}, 64'(start_c), 64'd1);
        check_eq({tag, "_signal_cycles"}, 64'(sig_c), 64'd32);
        check_eq({tag, "_signal_after"}, 64'(mul_signal), 64'd0);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_hi"}, 64'(hi), 64'(prod[63:32]));
        check_eq({tag, "_lo"}, 64'(lo), 64'(prod[31:0]));
        if (hold_mflo) begin
            check_eq({tag, "_rv_while_busy"}, 64'(rv_c + int'(result_valid)), 64'd0);
            tick();
            op_valid = 1'b0;
            check_eq({tag, "_held_rv"}, 64'(result_valid), 64'd1);
            check_eq({tag, "_held_result"}, 64'(result), 64'(prod[31:0]));
        end else begin
            tick();
            check_eq({tag, "_done_pulse_end"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; funct = 6'b0; data_in = '0; mul_product = '0;
        tick(); tick();
        reset = 1'b0;
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_outs", {59'd0, mul_start, done, result_valid, 2'b00}, 64'd0);
        check_eq("rst_signal", 64'(mul_signal), 64'd0);

        // 7 x 6
        run_mul("mul7x6", 64'h0000_0000_0000_002A, 1'b0);
        issue(c_MFLO, 32'h0);
        check_eq("mflo_rv", 64'(result_valid), 64'd1);
        check_eq("mflo_result", 64'(result), 64'h2A);
        tick();
        check_eq("mflo_rv_pulse", 64'(result_valid), 64'd0);

        // Full scale
        run_mul("mulfull", 64'hFFFF_FFFE_0000_0001, 1'b0);
        issue(c_MFHI, 32'h0);
        check_eq("mfhi_result", 64'(result), 64'hFFFF_FFFE);

        // MFLO held while busy
        run_mul("mulheld", 64'h0000_0003_0005_0000, 1'b1);

        // Register access, back to back
        done_cnt = 0;
        issue(c_MTHI, 32'h1234_5678);
        check_eq("mthi_hi", 64'(hi), 64'h1234_5678);
        check_eq("mthi_no_rv", 64'(result_valid), 64'd0);
        issue(c_MTLO, 32'h9ABC_DEF0);
        check_eq("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        issue(c_MFHI, 32'h0);
        check_eq("ra_mfhi_rv", 64'(result_valid), 64'd1);
        check_eq("ra_mfhi", 64'(result), 64'h1234_5678);
        issue(c_MFLO, 32'h0);
        check_eq("ra_mflo_rv", 64'(result_valid), 64'd1);
        check_eq("ra_mflo", 64'(result), 64'h9ABC_DEF0);
        // Unrecognised funct does nothing
        issue(6'b000000, 32'hDEAD_BEEF);
        check_eq("bad_fn_rv", 64'(result_valid), 64'd0);
        check_eq("bad_fn_busy", 64'(busy), 64'd0);
        check_eq("bad_fn_hi", 64'(hi), 64'h1234_5678);
        check_eq("bad_fn_lo", 64'(lo), 64'h9ABC_DEF0);
        tick();
        check_eq("ra_no_done", 64'(done_cnt), 64'd0);

        // Reset at cnt == 10
        mul_product = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(c_MULTU, 32'h0);
        repeat (10) tick();
        check_eq("mid_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_busy", 64'(busy), 64'd0);
        check_eq("mid_hi", 64'(hi), 64'd0);
        check_eq("mid_lo", 64'(lo), 64'd0);
        check_eq("mid_signal", 64'(mul_signal), 64'd0);
        run_mul("mul3x5", 64'h0000_0000_0000_000F, 1'b0);

        check_eq("done_rv_overlap", 64'(both_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
